// File: rtl/mc_control_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback and drives datapath selects.
// Latency 3-5 cycles per instruction; memory states stall until memReady, reset aborts without retiring.
module mc_control_fsm #(
  parameter int OPW  = 6,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            memReady,
  output logic            memRead,
  output logic            memWrite,
  output logic            iord,
  output logic            irWrite,
  output logic            pcWrite,
  output logic [1:0]      pcSrc,
  output logic            aluSrcA,
  output logic [1:0]      aluSrcB,
  output logic [1:0]      aluOp,
  output logic            regWrite,
  output logic [1:0]      regDst,
  output logic [1:0]      wbSrc,
  output logic            illegalOp,
  output logic [2:0]      state,
  output logic [CNTW-1:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEMRD  = 3'd3;
  localparam logic [2:0] S_MEMWR  = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_BRANCH = 3'd6;
  localparam logic [2:0] S_JUMP   = 3'd7;

  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
  localparam logic [OPW-1:0] OP_LW   = OPW'(2);
  localparam logic [OPW-1:0] OP_SW   = OPW'(3);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(4);
  localparam logic [OPW-1:0] OP_J    = OPW'(5);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(6);
  localparam logic [OPW-1:0] OP_JR   = OPW'(7);

  logic [2:0]      state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [CNTW-1:0] instret_q, instret_d;
  logic            retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: if (memReady) state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_R, OP_ADDI, OP_LW, OP_SW: state_d = S_EXEC;
          OP_BEQ:                      state_d = S_BRANCH;
          OP_J, OP_JAL, OP_JR:         state_d = S_JUMP;
          default:                     state_d = S_FETCH;
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_R, OP_ADDI: state_d = S_WB;
          OP_LW:         state_d = S_MEMRD;
          OP_SW:         state_d = S_MEMWR;
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEMRD: if (memReady) state_d = S_WB;
      S_MEMWR: begin
        if (memReady) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    instret_d = instret_q + CNTW'(retire);
  end

  always_comb begin
    memRead   = 1'b0;
    memWrite  = 1'b0;
    iord      = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    pcSrc     = 2'b00;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    regWrite  = 1'b0;
    regDst    = 2'b00;
    wbSrc     = 2'b00;
    illegalOp = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        aluSrcB   = 2'b11;
        illegalOp = (opcode > OP_JR);
      end
      S_EXEC: begin
        aluSrcA = 1'b1;
        if (op_q == OP_R) begin
          aluSrcB = 2'b00;
          aluOp   = 2'b10;
        end else begin
          aluSrcB = 2'b10;
          aluOp   = 2'b00;
        end
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        iord     = 1'b1;
      end
      S_WB: begin
        regWrite = 1'b1;
        regDst   = (op_q == OP_R)  ? 2'b01 : 2'b00;
        wbSrc    = (op_q == OP_LW) ? 2'b01 : 2'b00;
      end
      S_BRANCH: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b01;
        pcSrc   = 2'b01;
        pcWrite = zero;
      end
      S_JUMP: begin
        pcWrite = 1'b1;
        pcSrc   = (op_q == OP_JR) ? 2'b11 : 2'b10;
        if (op_q == OP_JAL) begin
          regWrite = 1'b1;
          regDst   = 2'b10;
          wbSrc    = 2'b10;
        end
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: each driven cycle queues its hand-computed expected
// state/control/instret; a negedge monitor pops and compares.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        memReady;
  logic        memRead, memWrite, iord, irWrite, pcWrite, aluSrcA, regWrite, illegalOp;
  logic [1:0]  pcSrc, aluSrcB, aluOp, regDst, wbSrc;
  logic [2:0]  state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  mc_control_fsm #(.OPW(6), .CNTW(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
    .memRead(memRead), .memWrite(memWrite), .iord(iord), .irWrite(irWrite),
    .pcWrite(pcWrite), .pcSrc(pcSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluOp(aluOp), .regWrite(regWrite), .regDst(regDst), .wbSrc(wbSrc),
    .illegalOp(illegalOp), .state(state), .instret(instret)
  );

  // Control word field order: memRead memWrite iord irWrite pcWrite pcSrc aluSrcA aluSrcB aluOp regWrite regDst wbSrc illegalOp
  localparam logic [17:0] C_FRDY  = 18'b1_0_0_1_1_00_0_01_00_0_00_00_0;
  localparam logic [17:0] C_FWAIT = 18'b1_0_0_0_0_00_0_01_00_0_00_00_0;
  localparam logic [17:0] C_DEC   = 18'b0_0_0_0_0_00_0_11_00_0_00_00_0;
  localparam logic [17:0] C_DILL  = 18'b0_0_0_0_0_00_0_11_00_0_00_00_1;
  localparam logic [17:0] C_EXR   = 18'b0_0_0_0_0_00_1_00_10_0_00_00_0;
  localparam logic [17:0] C_EXI   = 18'b0_0_0_0_0_00_1_10_00_0_00_00_0;
  localparam logic [17:0] C_MRD   = 18'b1_0_1_0_0_00_0_00_00_0_00_00_0;
  localparam logic [17:0] C_MWR   = 18'b0_1_1_0_0_00_0_00_00_0_00_00_0;
  localparam logic [17:0] C_WBR   = 18'b0_0_0_0_0_00_0_00_00_1_01_00_0;
  localparam logic [17:0] C_WBL   = 18'b0_0_0_0_0_00_0_00_00_1_00_01_0;
  localparam logic [17:0] C_WBI   = 18'b0_0_0_0_0_00_0_00_00_1_00_00_0;
  localparam logic [17:0] C_BRT   = 18'b0_0_0_0_1_01_1_00_01_0_00_00_0;
  localparam logic [17:0] C_BRN   = 18'b0_0_0_0_0_01_1_00_01_0_00_00_0;
  localparam logic [17:0] C_JJ    = 18'b0_0_0_0_1_10_0_00_00_0_00_00_0;
  localparam logic [17:0] C_JAL   = 18'b0_0_0_0_1_10_0_00_00_1_10_10_0;
  localparam logic [17:0] C_JR    = 18'b0_0_0_0_1_11_0_00_00_0_00_00_0;

  typedef struct packed {
    logic [15:0] row;
    logic [2:0]  st;
    logic [17:0] ctl;
    logic [31:0] ir;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;

  task automatic cyc(input logic r, input logic [5:0] op, input logic z, input logic mr,
                     input logic [2:0] st, input logic [17:0] ctl, input logic [31:0] ir);
    exp_t e;
    reset    = r;
    opcode   = op;
    zero     = z;
    memReady = mr;
    e.row = 16'(pushed);
    e.st  = st;
    e.ctl = ctl;
    e.ir  = ir;
    exp_q.push_back(e);
    pushed++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [17:0] act;
      e   = exp_q.pop_front();
      act = {memRead, memWrite, iord, irWrite, pcWrite, pcSrc, aluSrcA, aluSrcB,
             aluOp, regWrite, regDst, wbSrc, illegalOp};
      checks++;
      if (state !== e.st || act !== e.ctl || instret !== e.ir) begin
        errors++;
        $display("FAIL row%0d: got state=%0d ctl=%b instret=%0d, expected state=%0d ctl=%b instret=%0d",
                 e.row, state, act, instret, e.st, e.ctl, e.ir);
      end
    end
  end

  initial begin
    reset = 1'b0; opcode = '0; zero = 1'b0; memReady = 1'b0;
    @(posedge clk);
    #1;
    // Reset held: FETCH decode gated by memReady
    cyc(0, 6'h02, 0, 1, 3'd0, C_FRDY, 0);
    cyc(1, 6'h02, 0, 1, 3'd0, C_FRDY, 0);
    cyc(1, 6'h02, 0, 1, 3'd1, C_DEC, 0);
    cyc(1, 6'h02, 0, 1, 3'd2, C_EXI, 0);
    cyc(1, 6'h02, 0, 0, 3'd3, C_MRD, 0);
    // Async reset mid-MEMRD: immediate FETCH, no retire
    cyc(0, 6'h02, 0, 0, 3'd0, C_FWAIT, 0);
    cyc(0, 6'h02, 0, 1, 3'd0, C_FRDY, 0);
    cyc(1, 6'h02, 0, 1, 3'd0, C_FRDY, 0);
    // R-type; opcode changes after DECODE must be ignored
    cyc(1, 6'h00, 0, 1, 3'd1, C_DEC, 0);
    cyc(1, 6'h02, 0, 1, 3'd2, C_EXR, 0);
    cyc(1, 6'h03, 0, 1, 3'd5, C_WBR, 0);
    cyc(1, 6'h00, 0, 1, 3'd0, C_FRDY, 1);
    // LW with 3 wait cycles in MEMRD
    cyc(1, 6'h02, 0, 1, 3'd1, C_DEC, 1);
    cyc(1, 6'h02, 0, 1, 3'd2, C_EXI, 1);
    cyc(1, 6'h02, 0, 0, 3'd3, C_MRD, 1);
    cyc(1, 6'h02, 0, 0, 3'd3, C_MRD, 1);
    cyc(1, 6'h02, 0, 0, 3'd3, C_MRD, 1);
    cyc(1, 6'h02, 0, 1, 3'd3, C_MRD, 1);
    cyc(1, 6'h02, 0, 1, 3'd5, C_WBL, 1);
    cyc(1, 6'h00, 0, 0, 3'd0, C_FWAIT, 2);
    cyc(1, 6'h00, 0, 1, 3'd0, C_FRDY, 2);
    // BEQ taken then not taken
    cyc(1, 6'h04, 0, 1, 3'd1, C_DEC, 2);
    cyc(1, 6'h00, 1, 1, 3'd6, C_BRT, 2);
    cyc(1, 6'h00, 0, 1, 3'd0, C_FRDY, 3);
    cyc(1, 6'h04, 0, 1, 3'd1, C_DEC, 3);
    cyc(1, 6'h00, 0, 1, 3'd6, C_BRN, 3);
    cyc(1, 6'h00, 0, 1, 3'd0, C_FRDY, 4);
    // JAL then JR
    cyc(1, 6'h06, 0, 1, 3'd1, C_DEC, 4);
    cyc(1, 6'h07, 0, 1, 3'd7, C_JAL, 4);
    cyc(1, 6'h00, 0, 1, 3'd0, C_FRDY, 5);
    cyc(1, 6'h07, 0, 1, 3'd1, C_DEC, 5);
    cyc(1, 6'h06, 0, 1, 3'd7, C_JR, 5);
    cyc(1, 6'h00, 0, 1, 3'd0, C_FRDY, 6);
    // Illegal opcode: one-cycle pulse, back to FETCH, no retire
    cyc(1, 6'h3F, 0, 1, 3'd1, C_DILL, 6);
    cyc(1, 6'h3F, 0, 0, 3'd0, C_FWAIT, 6);
    cyc(1, 6'h00, 0, 1, 3'd0, C_FRDY, 6);
    // SW with one wait cycle in MEMWR
    cyc(1, 6'h03, 0, 1, 3'd1, C_DEC, 6);
    cyc(1, 6'h00, 0, 1, 3'd2, C_EXI, 6);
    cyc(1, 6'h00, 0, 0, 3'd4, C_MWR, 6);
    cyc(1, 6'h00, 0, 1, 3'd4, C_MWR, 6);
    cyc(1, 6'h00, 0, 1, 3'd0, C_FRDY, 7);
    // J then ADDI
    cyc(1, 6'h05, 0, 1, 3'd1, C_DEC, 7);
    cyc(1, 6'h07, 0, 1, 3'd7, C_JJ, 7);
    cyc(1, 6'h00, 0, 1, 3'd0, C_FRDY, 8);
    cyc(1, 6'h01, 0, 1, 3'd1, C_DEC, 8);
    cyc(1, 6'h00, 0, 1, 3'd2, C_EXI, 8);
    cyc(1, 6'h00, 0, 1, 3'd5, C_WBI, 8);
    cyc(1, 6'h00, 0, 0, 3'd0, C_FWAIT, 9);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || checks - 1 != pushed) begin
      errors++;
      $display("FAIL drain: got %0d pending, %0d checked, expected 0 pending, %0d checked",
               exp_q.size(), checks - 1, pushed);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
